// File: rtl/mult_pkg.sv
// Shared widths and FSM state encoding for the shift-add multiplier controller.
package mult_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned MUL_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPTURE,
        ST_WAIT
    } state_e;

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes and to restore the product sign.
module mult_sign_fix #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    // The most negative value negates to itself, which is exactly its magnitude as an unsigned number.
    assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer around an external shift-add multiplier: accepts an operand pair, runs the
// multiplier for MUL_CYCLES steps and returns a sign-corrected product through a ready/valid output register.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned DATA_W     = mult_pkg::DATA_W,
    parameter int unsigned MUL_CYCLES = mult_pkg::MUL_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic                  in_signed,
    output logic [DATA_W-1:0]     mul_num1,
    output logic [DATA_W-1:0]     mul_num2,
    output logic                  mul_load_n,
    input  logic [2*DATA_W-1:0]   mul_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_W-1:0]   res_data
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    num1_q, num1_d;
    logic [DATA_W-1:0]    num2_q, num2_d;
    logic                 sgn_q, sgn_d;
    logic                 neg_q, neg_d;
    logic                 res_valid_q, res_valid_d;
    logic [2*DATA_W-1:0]  res_data_q, res_data_d;

    logic [DATA_W-1:0]    mag_a, mag_b;
    logic [2*DATA_W-1:0]  res_fixed;

    mult_sign_fix #(.W(DATA_W)) u_fix_a (
        .val_i (in_a),
        .neg_i (in_signed & in_a[DATA_W-1]),
        .val_o (mag_a)
    );

    mult_sign_fix #(.W(DATA_W)) u_fix_b (
        .val_i (in_b),
        .neg_i (in_signed & in_b[DATA_W-1]),
        .val_o (mag_b)
    );

    mult_sign_fix #(.W(2*DATA_W)) u_fix_res (
        .val_i (mul_result),
        .neg_i (sgn_q & neg_q),
        .val_o (res_fixed)
    );

    // Reset gates the handshake outputs directly so they take effect without waiting for a clock.
    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign mul_load_n = (state_q != ST_LOAD) && !rst;
    assign mul_num1   = num1_q;
    assign mul_num2   = num2_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            sgn_q       <= 1'b0;
            neg_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            sgn_q       <= sgn_d;
            neg_q       <= neg_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        sgn_d       = sgn_q;
        neg_d       = neg_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        // A consumer handshake frees the register; a same-edge capture below re-fills it.
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (in_valid && in_ready) begin
                    num1_d  = mag_a;
                    num2_d  = mag_b;
                    sgn_d   = in_signed;
                    neg_d   = in_signed & (in_a[DATA_W-1] ^ in_b[DATA_W-1]);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE, ST_WAIT: begin
                if (!res_valid_q || res_ready) begin
                    res_data_d  = res_fixed;
                    res_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl with a behavioural shift-add multiplier attached.
module tb_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_signed = 1'b0;
    logic [15:0] mul_num1, mul_num2;
    logic        mul_load_n;
    logic [31:0] mul_result;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;

    int tests_run = 0;
    int fails     = 0;
    int delivered = 0;
    logic [31:0] sb[$];

    logic [31:0] m_acc, m_a;
    logic [15:0] m_b;
    logic [4:0]  m_cnt;

    always #5 clk = ~clk;

    mult_ctrl #(.DATA_W(16), .MUL_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_signed  (in_signed),
        .mul_num1   (mul_num1),
        .mul_num2   (mul_num2),
        .mul_load_n (mul_load_n),
        .mul_result (mul_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    // Shift-add multiplier: loads while its reset is low, then adds one partial product per edge.
    always @(posedge clk) begin
        if (!mul_load_n) begin
            m_acc <= '0;
            m_cnt <= '0;
            m_a   <= {16'h0000, mul_num1};
            m_b   <= mul_num2;
        end else if (m_cnt < 5'd16) begin
            if (m_b[m_cnt[3:0]]) m_acc <= m_acc + (m_a << m_cnt);
            m_cnt <= m_cnt + 5'd1;
        end
    end
    assign mul_result = m_acc;

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa, sbv;
        if (s) begin
            sa  = {{16{a[15]}}, a};
            sbv = {{16{b[15]}}, b};
            return sa * sbv;
        end
        return {16'h0000, a} * {16'h0000, b};
    endfunction

    function automatic logic [15:0] mag(input logic [15:0] v, input logic s);
        return (s && v[15]) ? (16'h0000 - v) : v;
    endfunction

    initial begin : monitor
        logic [31:0] exp_v;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
                tests_run++;
                delivered++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result: got %h expected none", res_data);
                end else begin
                    exp_v = sb.pop_front();
                    if (res_data !== exp_v) begin
                        fails++;
                        $display("FAIL result: got %h expected %h", res_data, exp_v);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input bit keep);
        bit ok;
        ok = 1'b0;
        in_a = a;
        in_b = b;
        in_signed = s;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            fails++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else begin
            sb.push_back(model(a, b, s));
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!done) begin
            fails++;
            $display("FAIL %s_drain: pending got %0d expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run += 6;
        if (in_ready !== 1'b0)    begin fails++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        if (mul_load_n !== 1'b0)  begin fails++; $display("FAIL rst_load_n: got %b expected 0", mul_load_n); end
        if (res_valid !== 1'b0)   begin fails++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
        if (res_data !== 32'h0)   begin fails++; $display("FAIL rst_res_data: got %h expected 0", res_data); end
        if (mul_num1 !== 16'h0)   begin fails++; $display("FAIL rst_num1: got %h expected 0", mul_num1); end
        if (mul_num2 !== 16'h0)   begin fails++; $display("FAIL rst_num2: got %h expected 0", mul_num2); end
        rst = 1'b0;
        #1;
        tests_run += 2;
        if (in_ready !== 1'b1)   begin fails++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
        if (mul_load_n !== 1'b1) begin fails++; $display("FAIL idle_load_n: got %b expected 1", mul_load_n); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int lat;
        lat = -1;
        res_ready = 1'b1;
        in_a = 16'd3;
        in_b = 16'd5;
        in_signed = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_ready: got %b expected 1", in_ready); end
        sb.push_back(32'h0000000F);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = 16'hAAAA;
        in_b = 16'h5555;
        tests_run++;
        if (mul_load_n !== 1'b0) begin fails++; $display("FAIL load_pulse: got %b expected 0", mul_load_n); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                tests_run++;
                if (mul_load_n !== 1'b1) begin fails++; $display("FAIL load_single: got %b expected 1", mul_load_n); end
            end
            if (k == 5) begin
                tests_run++;
                if (mul_num1 !== 16'd3 || mul_num2 !== 16'd5 || in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL operand_hold: got %h/%h rdy %b expected 0003/0005 rdy 0", mul_num1, mul_num2, in_ready);
                end
            end
            if (res_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests_run++;
        if (lat != 18) begin fails++; $display("FAIL latency: got %0d expected 18", lat); end
        wait_drain("latency");
    endtask

    task automatic test_products();
        logic [15:0] ta[6] = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'hFFFF, 16'h8000, 16'h1234};
        logic [15:0] tb_[6] = '{16'hFFFF, 16'h0005, 16'h8000, 16'h0000, 16'h0003, 16'h5678};
        logic        ts[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(ta[i], tb_[i], ts[i], 1'b0);
            tests_run++;
            if (mul_num1 !== mag(ta[i], ts[i]) || mul_num2 !== mag(tb_[i], ts[i])) begin
                fails++;
                $display("FAIL magnitude_%0d: got %h/%h expected %h/%h", i, mul_num1, mul_num2,
                         mag(ta[i], ts[i]), mag(tb_[i], ts[i]));
            end
            wait_drain("products");
        end
    endtask

    task automatic test_backpressure();
        int d0;
        logic [31:0] held;
        d0 = delivered;
        res_ready = 1'b0;
        send(16'd3, 16'd4, 1'b0, 1'b0);
        send(16'd5, 16'd6, 1'b0, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        held = sb[0];
        for (int k = 0; k < 10; k++) begin
            tests_run++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== held) begin
                fails++;
                $display("FAIL wait_hold: got rdy %b vld %b data %h expected rdy 0 vld 1 data %h",
                         in_ready, res_valid, res_data, held);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        wait_drain("backpressure");
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (delivered - d0 != 2 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_count: got %0d vld %b expected 2 vld 0", delivered - d0, res_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        res_ready = 1'b1;
        send(16'h1234, 16'h5678, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run += 3;
        if (mul_load_n !== 1'b0) begin fails++; $display("FAIL mid_rst_load_n: got %b expected 0", mul_load_n); end
        if (res_valid !== 1'b0)  begin fails++; $display("FAIL mid_rst_valid: got %b expected 0", res_valid); end
        if (in_ready !== 1'b0)   begin fails++; $display("FAIL mid_rst_ready: got %b expected 0", in_ready); end
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (res_data !== 32'h0 || mul_num1 !== 16'h0) begin
            fails++;
            $display("FAIL mid_rst_clear: got %h/%h expected 0/0", res_data, mul_num1);
        end
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (res_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin fails++; $display("FAIL stale_result: got valid 1 expected 0"); end
        send(16'd7, 16'd9, 1'b0, 1'b0);
        tests_run++;
        if (sb[$] !== 32'h0000003F) begin fails++; $display("FAIL post_rst_exp: got %h expected 0000003F", sb[$]); end
        wait_drain("reset_mid");
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [15:0] ba[4] = '{16'd11, 16'hFFF0, 16'h00FF, 16'h7FFF};
        logic [15:0] bb[4] = '{16'd13, 16'h0010, 16'h0101, 16'hFFFF};
        logic        bs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        d0 = delivered;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(ba[i], bb[i], bs[i], (i < 3));
        end
        wait_drain("back_to_back");
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (delivered - d0 != 4 || sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_count: got %0d expected 4", delivered - d0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_products();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, operand width; SHALL match the downstream shift-add multiplier (result width 2*DATA_W).
REQ-002 Parameter: MUL_CYCLES, 16, multiplier step count; SHALL equal DATA_W.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  controller can accept an operand pair.
REQ-007 in_a  input  DATA_W  multiplicand.
REQ-008 in_b  input  DATA_W  multiplier operand.
REQ-009 in_signed  input  1  1 = treat in_a/in_b as two's complement; 0 = unsigned.
REQ-010 mul_num1  output  DATA_W  magnitude of in_a, driven to the multiplier's num1.
REQ-011 mul_num2  output  DATA_W  magnitude of in_b, driven to the multiplier's num2.
REQ-012 mul_load_n  output  1  drives the multiplier's active-low rst; low = load operands and clear the step count.
REQ-013 mul_result  input  2*DATA_W  unsigned product from the multiplier.
REQ-014 res_valid  output  1  result held in the output register.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_data  output  2*DATA_W  final product, sign-corrected when in_signed was 1.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, CAPTURE and WAIT.
REQ-018 IDLE: in_ready=1; in_valid&in_ready SHALL register the magnitudes, in_signed and neg=(in_signed & (a[msb]^b[msb])), then go to LOAD.
REQ-019 Magnitude: if in_signed and msb=1, two's-complement negate; otherwise pass through unchanged; -32768 SHALL map to 0x8000.
REQ-020 LOAD: mul_load_n=0 for exactly one cycle, then go to RUN.
REQ-021 RUN: mul_load_n=1; a step counter SHALL count MUL_CYCLES edges, then go to CAPTURE.
REQ-022 CAPTURE: if res_valid=0 or res_ready=1, SHALL load res_data, set res_valid=1 and go to IDLE; otherwise go to WAIT.
REQ-023 WAIT: hold mul_load_n=1 (multiplier idle, product stable) and SHALL perform the CAPTURE action on the first cycle res_ready=1.
REQ-024 Sign fix: res_data = neg ? -mul_result (mod 2^32) : mul_result; a zero product SHALL yield 0.
REQ-025 Latency: res_valid SHALL rise exactly MUL_CYCLES+2 = 18 edges after the accepting edge when the output register is free.
REQ-026 res_valid SHALL clear on res_valid&res_ready unless a capture occurs on the same edge, in which case it SHALL stay 1 with the new data.
REQ-027 res_data SHALL stay stable while res_valid=1 and res_ready=0.
REQ-028 in_ready SHALL be 0 in LOAD, RUN, CAPTURE and WAIT; a second operand pair SHALL NOT be accepted until IDLE.
REQ-029 in_valid changes outside IDLE SHALL be ignored; operand registers SHALL change only on acceptance.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, step counter 0, mul_load_n=0, res_valid=0, res_data=0, mul_num1=mul_num2=0 and in_ready=0 while asserted.
REQ-031 Reset during RUN or WAIT SHALL discard the in-flight operation; after release no result for it SHALL appear.

Structure
REQ-032 Shared package mult_pkg SHALL hold DATA_W, MUL_CYCLES and the FSM state typedef.
REQ-033 Sign handling (magnitude in, conditional negate out) SHALL be one combinational sub-module, mult_sign_fix, instantiated for operands and result.

Verification
REQ-034 unsigned 3*5, res_ready=1 -> res_data=0x0000000F, res_valid 18 edges after accept.
REQ-035 unsigned 0xFFFF*0xFFFF -> 0xFFFE0001.
REQ-036 signed 0xFFFD(-3)*0x0005 -> 0xFFFFFFF1; signed 0x8000*0x8000 -> 0x40000000; signed 0xFFFF*0x0000 -> 0x00000000.
REQ-037 res_ready=0 for 10 cycles after completion -> WAIT held, in_ready=0, res_data stable; on res_ready=1 result delivered once.
REQ-038 rst pulsed at RUN step 8 -> mul_load_n=0, res_valid=0 at once; a new op 7*9 after release -> 0x0000003F.
REQ-039 back-to-back ops, in_valid held high -> exactly one accept per IDLE, results in order, none lost or duplicated.
